// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared bus-width defines, fetch FSM state encoding and PC step
// for the instruction-fetch stage.

`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif

`ifndef INST_BUS
`define INST_BUS 31:0
`endif

package if_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: request/acknowledge bus between the fetch stage (master) and
// the instruction ROM (slave).

interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);

  logic              o_romReq;
  logic [ADDR_W-1:0] o_romAddr;
  logic              i_romAck;
  logic [INST_W-1:0] i_romInst;

  modport master (
    output o_romReq,
    output o_romAddr,
    input  i_romAck,
    input  i_romInst
  );

  modport slave (
    input  o_romReq,
    input  o_romAddr,
    output i_romAck,
    output i_romInst
  );

endinterface

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry pc+inst holding buffer. Flush beats load, load beats
// drain. Only the occupancy flag is reset; the payload is captured on load.

module if_skid_buf #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic              valid_q;
  logic              valid_d;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;

  // Occupancy next-state: flush, then load, then drain
  always_comb begin
    valid_d = valid_q;
    if (flush_i)      valid_d = 1'b0;
    else if (load_i)  valid_d = 1'b1;
    else if (drain_i) valid_d = 1'b0;
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // Payload capture
  always_ff @(posedge clk) begin
    if (load_i) begin
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the PC, fetches over the ROM
// req/ack bus, presents (pc, inst, valid) to IF/ID, absorbs one stalled
// response in a skid buffer and squashes in-flight responses on redirect.
// Optional build macro IF_FETCH_PERF_CNT_EN adds saturating fetch/drop counters.

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_if.master        rom,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirectPc,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       o_fetchCnt,
  output logic [31:0]       o_dropCnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  logic              skid_load, skid_drain, skid_flush;
  logic              skid_valid;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;

  logic              ack;
  logic              slot_busy;
  logic              consume;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] redir_pc_al;

  assign ack         = rom.i_romAck;
  assign slot_busy   = valid_q & i_stall;
  assign consume     = valid_q & ~i_stall;
  assign pc_next     = fetch_pc_q + ADDR_W'(PC_STEP);
  assign redir_pc_al = i_redirectPc & ~ADDR_W'(3);

  if_skid_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (skid_flush),
    .pc_i    (req_addr_q),
    .inst_i  (rom.i_romInst),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a redirect with a request still waiting for its ack
  // must park in S_DROP to swallow that ack
  always_comb begin
    state_d = state_q;
    if (i_redirect) begin
      state_d = (req_q & ~ack) ? S_DROP : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   if (ack && slot_busy) state_d = S_HOLD;
        S_HOLD:  if (consume) state_d = S_IDLE;
        S_DROP:  if (ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and bus controls; an unstalled valid slot empties unless refilled
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    req_d      = req_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = slot_busy;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_flush = 1'b0;
    if (i_redirect) begin
      fetch_pc_d = redir_pc_al;
      valid_d    = 1'b0;
      skid_flush = 1'b1;
      req_d      = req_q & ~ack;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_d      = 1'b1;
          req_addr_d = fetch_pc_q;
        end
        S_REQ: begin
          if (ack) begin
            fetch_pc_d = pc_next;
            if (!slot_busy) begin
              pc_d       = req_addr_q;
              inst_d     = rom.i_romInst;
              valid_d    = 1'b1;
              req_addr_d = pc_next;
            end else begin
              skid_load = 1'b1;
              req_d     = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            pc_d       = skid_pc;
            inst_d     = skid_inst;
            valid_d    = 1'b1;
            skid_drain = 1'b1;
          end
        end
        S_DROP: begin
          if (ack) req_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Fetch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  assign rom.o_romReq  = req_q;
  assign rom.o_romAddr = req_addr_q;
  assign if_pc         = pc_q;
  assign if_inst       = inst_q;
  assign if_valid      = valid_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        ack_taken;
  logic        ack_dropped;
  logic [1:0]  drop_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + 33'(inc);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  assign ack_taken   = ack & ~i_redirect & (state_q == S_REQ);
  assign ack_dropped = ack & req_q & (i_redirect | (state_q == S_DROP));
  assign drop_inc    = 2'(ack_dropped) + 2'(i_redirect & slot_busy) + 2'(i_redirect & skid_valid);

  // Counter increments: accepted acks, and discarded acks plus flushed entries
  always_comb begin
    fetch_cnt_d = sat_add(fetch_cnt_q, 2'(ack_taken));
    drop_cnt_d  = sat_add(drop_cnt_q, drop_inc);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_fetchCnt = fetch_cnt_q;
  assign o_dropCnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed-vector bench for if_fetch; the bench plays the ROM.

module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redir_pc;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;
`endif

  int total;
  int bad;

  if_fetch_if #(.ADDR_W(32), .INST_W(32)) rom_if ();

  if_fetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom          (rom_if),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirectPc (redir_pc),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .o_fetchCnt   (fetch_cnt),
    .o_dropCnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled at its edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_with(input logic [31:0] a);
    rom_if.i_romAck  = 1'b1;
    rom_if.i_romInst = inst_of(a);
  endtask

  task automatic no_ack();
    rom_if.i_romAck  = 1'b0;
    rom_if.i_romInst = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redir_pc = 32'h0;
    no_ack();
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // ---- reset values and back-to-back fetch ----
    do_reset();
    chk_eq("rst_req",   32'(rom_if.o_romReq), 32'd0);
    chk_eq("rst_valid", 32'(if_valid), 32'd0);
    chk_eq("rst_pc",    if_pc, 32'h0);
    chk_eq("rst_inst",  if_inst, 32'h0);
    cyc();
    chk_eq("b2b_req0",   32'(rom_if.o_romReq), 32'd1);
    chk_eq("b2b_addr0",  rom_if.o_romAddr, 32'h0);
    chk_eq("b2b_bubble", 32'(if_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ack_with(32'(i * 4));
      cyc();
      chk_eq("b2b_valid", 32'(if_valid), 32'd1);
      chk_eq("b2b_pc",    if_pc, 32'(i * 4));
      chk_eq("b2b_inst",  if_inst, inst_of(32'(i * 4)));
      chk_eq("b2b_addr",  rom_if.o_romAddr, 32'((i + 1) * 4));
      chk_eq("b2b_req",   32'(rom_if.o_romReq), 32'd1);
    end
    no_ack();
    cyc();
    chk_eq("noack_valid", 32'(if_valid), 32'd0);
    chk_eq("noack_pc",    if_pc, 32'h8);
    chk_eq("noack_addr",  rom_if.o_romAddr, 32'hC);
    chk_eq("noack_req",   32'(rom_if.o_romReq), 32'd1);

    // ---- stall into the skid buffer ----
    do_reset();
    cyc();
    ack_with(32'h0); cyc();
    ack_with(32'h4); cyc();
    chk_eq("stl_pc4", if_pc, 32'h4);
    stall = 1'b1;
    ack_with(32'h8); cyc();
    chk_eq("stl_req",   32'(rom_if.o_romReq), 32'd0);
    chk_eq("stl_pc",    if_pc, 32'h4);
    chk_eq("stl_valid", 32'(if_valid), 32'd1);
    no_ack(); cyc();
    chk_eq("stl_hold_req", 32'(rom_if.o_romReq), 32'd0);
    cyc();
    chk_eq("stl_hold_pc", if_pc, 32'h4);
    stall = 1'b0; cyc();
    chk_eq("stl_drain_pc",    if_pc, 32'h8);
    chk_eq("stl_drain_inst",  if_inst, inst_of(32'h8));
    chk_eq("stl_drain_valid", 32'(if_valid), 32'd1);
    chk_eq("stl_drain_req",   32'(rom_if.o_romReq), 32'd0);
    cyc();
    chk_eq("stl_after_valid", 32'(if_valid), 32'd0);
    chk_eq("stl_after_req",   32'(rom_if.o_romReq), 32'd1);
    chk_eq("stl_after_addr",  rom_if.o_romAddr, 32'hC);

    // ---- redirect with request in flight, late ack dropped ----
    do_reset();
    cyc();
    for (int i = 0; i < 4; i++) begin
      ack_with(32'(i * 4));
      cyc();
    end
    chk_eq("drp_pre_pc",   if_pc, 32'hC);
    chk_eq("drp_pre_addr", rom_if.o_romAddr, 32'h10);
    no_ack();
    redirect = 1'b1; redir_pc = 32'h100; cyc();
    redirect = 1'b0;
    chk_eq("drp_req",   32'(rom_if.o_romReq), 32'd1);
    chk_eq("drp_addr",  rom_if.o_romAddr, 32'h10);
    chk_eq("drp_valid", 32'(if_valid), 32'd0);
    cyc();
    chk_eq("drp_wait_addr", rom_if.o_romAddr, 32'h10);
    ack_with(32'h10); cyc();
    no_ack();
    chk_eq("drp_ack_req",   32'(rom_if.o_romReq), 32'd0);
    chk_eq("drp_ack_valid", 32'(if_valid), 32'd0);
    cyc();
    chk_eq("drp_new_req",  32'(rom_if.o_romReq), 32'd1);
    chk_eq("drp_new_addr", rom_if.o_romAddr, 32'h100);
    ack_with(32'h100); cyc();
    no_ack();
    chk_eq("drp_first_pc",    if_pc, 32'h100);
    chk_eq("drp_first_inst",  if_inst, inst_of(32'h100));
    chk_eq("drp_first_valid", 32'(if_valid), 32'd1);
`ifdef IF_FETCH_PERF_CNT_EN
    chk_eq("drp_dropcnt",  drop_cnt, 32'd1);
    chk_eq("drp_fetchcnt", fetch_cnt, 32'd5);
`endif

    // ---- redirect coincident with ack; misaligned target ----
    do_reset();
    redirect = 1'b1; redir_pc = 32'h22; cyc();
    redirect = 1'b0;
    chk_eq("coin_idle_req", 32'(rom_if.o_romReq), 32'd0);
    cyc();
    chk_eq("coin_addr", rom_if.o_romAddr, 32'h20);
    ack_with(32'h20);
    redirect = 1'b1; redir_pc = 32'h40; cyc();
    redirect = 1'b0;
    no_ack();
    chk_eq("coin_valid", 32'(if_valid), 32'd0);
    chk_eq("coin_pc",    if_pc, 32'h0);
    chk_eq("coin_req",   32'(rom_if.o_romReq), 32'd0);
    cyc();
    chk_eq("coin_new_addr", rom_if.o_romAddr, 32'h40);
    ack_with(32'h40); cyc();
    no_ack();
    chk_eq("coin_first_pc", if_pc, 32'h40);

    // ---- PC wrap at top of address space ----
    do_reset();
    redirect = 1'b1; redir_pc = 32'hFFFF_FFFF; cyc();
    redirect = 1'b0; cyc();
    chk_eq("wrap_addr", rom_if.o_romAddr, 32'hFFFF_FFFC);
    ack_with(32'hFFFF_FFFC); cyc();
    chk_eq("wrap_pc0",   if_pc, 32'hFFFF_FFFC);
    chk_eq("wrap_addr1", rom_if.o_romAddr, 32'h0);
    ack_with(32'h0); cyc();
    no_ack();
    chk_eq("wrap_pc1",   if_pc, 32'h0);
    chk_eq("wrap_inst1", if_inst, inst_of(32'h0));
    chk_eq("wrap_addr2", rom_if.o_romAddr, 32'h4);

    // ---- reset while in S_DROP with stall high ----
    do_reset();
    cyc();
    ack_with(32'h0); cyc();
    no_ack();
    stall = 1'b1;
    redirect = 1'b1; redir_pc = 32'h80; cyc();
    redirect = 1'b0;
    chk_eq("rdrp_req",   32'(rom_if.o_romReq), 32'd1);
    chk_eq("rdrp_addr",  rom_if.o_romAddr, 32'h4);
    chk_eq("rdrp_valid", 32'(if_valid), 32'd0);
    rst = 1'b1; ack_with(32'h4); cyc();
    rst = 1'b0; no_ack();
    chk_eq("rdrp_rst_req",   32'(rom_if.o_romReq), 32'd0);
    chk_eq("rdrp_rst_valid", 32'(if_valid), 32'd0);
    chk_eq("rdrp_rst_pc",    if_pc, 32'h0);
    chk_eq("rdrp_rst_inst",  if_inst, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk_eq("rdrp_rst_dropcnt", drop_cnt, 32'd0);
`endif
    cyc();
    chk_eq("rdrp_new_req",  32'(rom_if.o_romReq), 32'd1);
    chk_eq("rdrp_new_addr", rom_if.o_romAddr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the program counter and issues requests to the instruction ROM over a req/ack handshake.
- Delivers (pc, inst) pairs with a valid flag to the IF/ID pipeline register.
- Absorbs downstream stalls with a one-entry skid buffer.
- Handles branch/jump redirects from later stages, including squashing an in-flight ROM response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of the instruction address (matches `INST_ADDR_BUS).
- INST_W, 32, width of the instruction word (matches `INST_BUS).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- o_romReq  out  1  ROM request; held high until i_romAck.
- o_romAddr  out  ADDR_W  request address; stable while o_romReq=1.
- i_romAck  in  1  ROM response valid, one-cycle pulse. Arrives no earlier than the cycle after o_romReq rises.
- i_romInst  in  INST_W  ROM data, valid when i_romAck=1.
- i_stall  in  1  downstream not accepting this cycle.
- i_redirect  in  1  flush and restart fetch at i_redirectPc.
- i_redirectPc  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- if_pc  out  ADDR_W  PC of the delivered instruction.
- if_inst  out  INST_W  delivered instruction.
- if_valid  out  1  if_pc/if_inst hold a live instruction.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC, req_addr=RESET_PC.
  - o_romReq=0, if_valid=0, if_pc=0, if_inst=0, skid buffer empty, state=S_IDLE.
  - rst overrides every other input. Reset mid-request discards the pending ack.
- Transfer rule: downstream consumes the output slot on any cycle where if_valid=1 and i_stall=0.
- S_IDLE:
  - Next cycle: o_romReq=1, req_addr=fetch_pc, state=S_REQ.
  - This costs one bubble cycle after reset and after each redirect.
- S_REQ, ack received with the output slot free or being consumed:
  - Load if_inst<=i_romInst, if_pc<=req_addr, if_valid<=1.
  - fetch_pc+=4 (mod 2^ADDR_W; wraps 0xFFFF_FFFC -> 0).
  - Reissue immediately with req_addr=fetch_pc+4, keeping o_romReq=1. This gives back-to-back throughput of one instruction per ack.
- S_REQ, ack received with the slot occupied and stalled:
  - Write the instruction into the skid buffer, fetch_pc+=4.
  - o_romReq<=0, state=S_HOLD.
- S_HOLD:
  - No requests issued.
  - When the slot is consumed, skid moves to the output slot; then go to S_IDLE.
- S_REQ, no ack: hold o_romReq and o_romAddr unchanged.
- Redirect (priority below rst, above stall and ack):
  - fetch_pc<=i_redirectPc&~3.
  - if_valid<=0, skid cleared.
  - Any ack in the same cycle is discarded.
  - If a request is outstanding with no ack this cycle: state=S_DROP and o_romReq stays high on the old req_addr.
  - Otherwise: o_romReq<=0, state=S_IDLE.
- S_DROP:
  - On ack, discard the data, o_romReq<=0, go to S_IDLE.
  - A further redirect while in S_DROP updates only fetch_pc.
- if_pc/if_inst hold their values while if_valid=0 or while stalled.
- Latency: ROM ack to if_valid is 1 cycle. Redirect to new o_romReq is 2 cycles when nothing is in flight.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs o_fetchCnt[31:0] (count of accepted non-discarded acks) and o_dropCnt[31:0] (count of discarded acks plus flushed valid/skid entries).
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and are unaffected by stall.
- When undefined: the ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared defines/package holds:
  - `INST_ADDR_BUS and `INST_BUS (existing).
  - State encodings S_IDLE=2'd0, S_REQ=2'd1, S_HOLD=2'd2, S_DROP=2'd3.
  - PC_STEP=4.
- One natural sub-module: if_skid_buf, a 1-entry pc+inst buffer with load/drain/flush. Everything else stays in if_fetch.

Test Plan:
- Reset, then ROM acks each cycle after request -> o_romAddr 0,4,8,12; if_pc 0,4,8 on consecutive cycles with if_valid=1.
- i_stall=1 for 3 cycles while the ack for addr 8 arrives -> skid holds pc 8, o_romReq=0. After release: pc 4 is consumed, then pc 8, then the request for 12 issues.
- Redirect to 0x100 while the request for 0x10 is outstanding, ack 2 cycles later -> that ack is discarded. Next o_romAddr=0x100; first valid if_pc=0x100. With IF_FETCH_PERF_CNT_EN, o_dropCnt increments by 1.
- Redirect in the same cycle as an ack for 0x20 -> if_valid=0 next cycle and 0x20 is never delivered.
- i_redirectPc=0xFFFF_FFFC, two acks -> if_pc 0xFFFF_FFFC then 0x0000_0000.
- Assert rst during S_DROP with stall high -> all outputs return to reset values next cycle. The first new request addr=RESET_PC.
